// File: rtl/vector_load_controller.sv
// Streams job elements from element memory to the vector constructor, one vector at a time,
// and launches the multiplier once per completed vector.
module vector_load_controller #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int ADDR_WIDTH       = 3,
  parameter int VECTOR_DIMENSION = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH:0]      element_count,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic                     mem_rd_en,
  input  logic [ELEMENT_WIDTH-1:0] mem_data,
  output logic [ELEMENT_WIDTH-1:0] element_out,
  output logic                     element_valid,
  input  logic                     vector_ready,
  output logic                     mult_start,
  input  logic                     mult_busy,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_VEC, ISSUE, WAIT_MULT, DONE} state_t;

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] VEC_DIM   = CW'(VECTOR_DIMENSION);
  localparam logic [CW-1:0] BEAT_LAST = VEC_DIM - 1'b1;
  localparam logic [CW-1:0] MAX_COUNT = CW'(1 << ADDR_WIDTH);
  localparam logic [3:0]    TIMEOUT_LAST = 4'd15;

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [CW-1:0]            left_reg;
  logic [CW-1:0]            beat_reg;
  logic [3:0]               timer_reg;
  logic                     wm_armed_reg;
  logic                     valid_reg;
  logic                     error_reg;
  logic [ELEMENT_WIDTH-1:0] hold_reg;

  logic count_ok;
  logic fetch_last;
  logic timeout;
  logic job_error;

  assign count_ok   = (element_count != '0) && ((element_count % VEC_DIM) == '0) &&
                      (element_count <= MAX_COUNT);
  assign fetch_last = (beat_reg == BEAT_LAST);
  assign timeout    = (state_reg == WAIT_VEC) && !vector_ready && (timer_reg == TIMEOUT_LAST);
  assign job_error  = ((state_reg == IDLE) && start && !count_ok) || timeout;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start && count_ok) state_next = FETCH;
      FETCH:     if (fetch_last) state_next = WAIT_VEC;
      WAIT_VEC:  if (vector_ready) state_next = ISSUE;
                 else if (timeout) state_next = IDLE;
      ISSUE:     if (!mult_busy) state_next = WAIT_MULT;
      // The multiplier's busy flag lags mult_start by a cycle, so the first cycle is not trusted.
      WAIT_MULT: if (wm_armed_reg && !mult_busy) state_next = (left_reg != '0) ? FETCH : DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en     = (state_reg == FETCH);
    mult_start    = (state_reg == ISSUE) && !mult_busy;
    busy          = (state_reg != IDLE);
    done          = (state_reg == DONE);
    error         = error_reg;
    mem_addr      = addr_reg;
    element_valid = valid_reg;
    element_out   = valid_reg ? mem_data : hold_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= '0;
      left_reg     <= '0;
      beat_reg     <= '0;
      timer_reg    <= '0;
      wm_armed_reg <= 1'b0;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
      hold_reg     <= '0;
    end else begin
      valid_reg    <= (state_reg == FETCH);
      error_reg    <= job_error;
      wm_armed_reg <= (state_reg == WAIT_MULT);
      timer_reg    <= (state_reg == WAIT_VEC) ? timer_reg + 1'b1 : '0;
      if (valid_reg) hold_reg <= mem_data;
      case (state_reg)
        IDLE: begin
          if (start && count_ok) begin
            addr_reg <= '0;
            left_reg <= element_count;
            beat_reg <= '0;
          end
        end
        FETCH: begin
          addr_reg <= addr_reg + 1'b1;
          left_reg <= left_reg - 1'b1;
          beat_reg <= fetch_last ? '0 : beat_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_controller.sv
// Directed bench for vector_load_controller: scripted cycle-by-cycle stimulus with a
// one-cycle-latency memory model and hand-computed expectations.
module tb_vector_load_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  element_count;
  logic [2:0]  mem_addr;
  logic        mem_rd_en;
  logic [23:0] mem_data;
  logic [23:0] element_out;
  logic        element_valid;
  logic        vector_ready;
  logic        mult_start;
  logic        mult_busy;
  logic        busy;
  logic        done;
  logic        error;

  vector_load_controller #(
    .ELEMENT_WIDTH(24),
    .ADDR_WIDTH(3),
    .VECTOR_DIMENSION(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .element_count(element_count),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_data(mem_data),
    .element_out(element_out),
    .element_valid(element_valid),
    .vector_ready(vector_ready),
    .mult_start(mult_start),
    .mult_busy(mult_busy),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [0:7];
  logic [23:0] exp_elems [0:5];

  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem[mem_addr];
  end

  int passes = 0;
  int checks = 0;

  // Values sampled on the falling edge of the most recent cycle
  logic [2:0]  s_addr;
  logic        s_rd_en, s_valid, s_mstart, s_busy, s_done, s_error;
  logic [23:0] s_out;
  int ev_cnt, rd_cnt, ms_cnt, done_cnt, err_cnt;
  logic [23:0] ev_log [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_counts();
    ev_cnt = 0; rd_cnt = 0; ms_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the following falling edge.
  task automatic cyc();
    @(negedge clk);
    s_addr   = mem_addr;
    s_rd_en  = mem_rd_en;
    s_valid  = element_valid;
    s_out    = element_out;
    s_mstart = mult_start;
    s_busy   = busy;
    s_done   = done;
    s_error  = error;
    if (element_valid && ev_cnt < 16) begin
      ev_log[ev_cnt] = element_out;
      ev_cnt++;
    end
    if (mem_rd_en)  rd_cnt++;
    if (mult_start) ms_cnt++;
    if (done)       done_cnt++;
    if (error)      err_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"},   32'(s_addr),   0);
    chk({tag, "_rd_en"},  32'(s_rd_en),  0);
    chk({tag, "_out"},    32'(s_out),    0);
    chk({tag, "_valid"},  32'(s_valid),  0);
    chk({tag, "_mstart"}, 32'(s_mstart), 0);
    chk({tag, "_busy"},   32'(s_busy),   0);
    chk({tag, "_done"},   32'(s_done),   0);
    chk({tag, "_error"},  32'(s_error),  0);
  endtask

  // One vector: 3 fetch cycles, rdy_delay WAIT_VEC cycles, pre_busy stalled ISSUE cycles,
  // one idle WAIT_MULT cycle, busy_len busy cycles, then the WAIT_MULT exit cycle.
  task automatic do_vector(input int base, input int rdy_delay, input int pre_busy, input int busy_len);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("vec_rd_en", 32'(s_rd_en), 1);
      chk("vec_addr", 32'(s_addr), 32'(base + i));
    end
    vector_ready = 1'b0;
    for (int i = 0; i < rdy_delay; i++) begin
      cyc();
      chk("vec_wait_mstart", 32'(s_mstart), 0);
    end
    vector_ready = 1'b1;
    cyc();
    vector_ready = 1'b0;
    mult_busy = 1'b1;
    for (int i = 0; i < pre_busy; i++) begin
      cyc();
      chk("vec_stall_mstart", 32'(s_mstart), 0);
      chk("vec_stall_busy", 32'(s_busy), 1);
    end
    mult_busy = 1'b0;
    cyc();
    chk("vec_mstart", 32'(s_mstart), 1);
    cyc();
    chk("vec_wm_first_busy", 32'(s_busy), 1);
    mult_busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      cyc();
      chk("vec_wm_mstart", 32'(s_mstart), 0);
    end
    mult_busy = 1'b0;
    cyc();
  endtask

  initial begin
    mem[0] = 24'h00AA00; mem[1] = 24'h01B480; mem[2] = 24'h005916;
    mem[3] = 24'h0015F0; mem[4] = 24'h45557E; mem[5] = 24'h020000;
    mem[6] = 24'h123456; mem[7] = 24'h654321;
    exp_elems[0] = 24'h00AA00; exp_elems[1] = 24'h01B480; exp_elems[2] = 24'h005916;
    exp_elems[3] = 24'h0015F0; exp_elems[4] = 24'h45557E; exp_elems[5] = 24'h020000;
    mem_data = '0;
    reset = 1'b1; start = 1'b0; element_count = '0; vector_ready = 1'b0; mult_busy = 1'b0;
    clr_counts();

    // Reset held five cycles
    repeat (5) cyc();
    check_all_zero("rst");
    reset = 1'b0;

    // Normal job: six elements, two vectors
    clr_counts();
    start = 1'b1; element_count = 4'd6;
    cyc();
    chk("norm_idle_busy", 32'(s_busy), 0);
    start = 1'b0;
    do_vector(0, 2, 0, 3);
    do_vector(3, 2, 0, 3);
    cyc();
    chk("norm_done", 32'(s_done), 1);
    chk("norm_done_busy", 32'(s_busy), 1);
    cyc();
    chk("norm_after_done", 32'(s_done), 0);
    chk("norm_after_busy", 32'(s_busy), 0);
    chk("norm_hold_valid", 32'(s_valid), 0);
    chk("norm_hold_out", 32'(s_out), 32'h020000);
    chk("norm_ev_cnt", 32'(ev_cnt), 6);
    chk("norm_rd_cnt", 32'(rd_cnt), 6);
    chk("norm_ms_cnt", 32'(ms_cnt), 2);
    chk("norm_done_cnt", 32'(done_cnt), 1);
    chk("norm_err_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 6; i++) chk("norm_elem", 32'(ev_log[i]), 32'(exp_elems[i]));

    // Illegal counts: not a multiple, zero, above memory size
    clr_counts();
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      element_count = (k == 0) ? 4'd4 : (k == 1) ? 4'd0 : 4'd9;
      cyc();
      chk("ill_start_busy", 32'(s_busy), 0);
      start = 1'b0;
      cyc();
      chk("ill_error", 32'(s_error), 1);
      chk("ill_busy", 32'(s_busy), 0);
      cyc();
      chk("ill_error_clear", 32'(s_error), 0);
    end
    chk("ill_err_cnt", 32'(err_cnt), 3);
    chk("ill_rd_cnt", 32'(rd_cnt), 0);

    // Backpressure: multiplier busy for five cycles on ISSUE entry
    clr_counts();
    start = 1'b1; element_count = 4'd3;
    cyc();
    start = 1'b0;
    do_vector(0, 0, 5, 2);
    cyc();
    chk("bp_done", 32'(s_done), 1);
    cyc();
    chk("bp_idle_busy", 32'(s_busy), 0);
    chk("bp_ms_cnt", 32'(ms_cnt), 1);
    chk("bp_ev_cnt", 32'(ev_cnt), 3);

    // Timeout: vector_ready asserted only during FETCH (ignored), starts while busy ignored
    clr_counts();
    start = 1'b1; element_count = 4'd3;
    cyc();
    start = 1'b0;
    vector_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("to_fetch_rd_en", 32'(s_rd_en), 1);
    end
    vector_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      start = (i == 5 || i == 6);
      element_count = (i == 5) ? 4'd4 : 4'd6;
      cyc();
      chk("to_wait_busy", 32'(s_busy), 1);
      chk("to_wait_error", 32'(s_error), 0);
    end
    start = 1'b0;
    cyc();
    chk("to_error", 32'(s_error), 1);
    chk("to_idle_busy", 32'(s_busy), 0);
    cyc();
    chk("to_error_clear", 32'(s_error), 0);
    chk("to_ms_cnt", 32'(ms_cnt), 0);
    chk("to_rd_cnt", 32'(rd_cnt), 3);
    chk("to_err_cnt", 32'(err_cnt), 1);

    // Mid-job reset while reading address 2
    clr_counts();
    start = 1'b1; element_count = 4'd6;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk("mjr_addr_before", 32'(s_addr), 2);
    chk("mjr_rd_before", 32'(s_rd_en), 1);
    reset = 1'b0;
    cyc();
    check_all_zero("mjr");
    start = 1'b1; element_count = 4'd3;
    cyc();
    start = 1'b0;
    do_vector(0, 1, 0, 1);
    cyc();
    chk("mjr_done", 32'(s_done), 1);
    cyc();
    chk("mjr_idle_busy", 32'(s_busy), 0);
    chk("mjr_ev_cnt", 32'(ev_cnt), 5);
    chk("mjr_last_elem", 32'(ev_log[4]), 32'(exp_elems[2]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vector_load_controller.md
VECTOR_LOAD_CONTROLLER -- requirements
Module: vector_load_controller

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 24, element bit width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, element memory address width.
REQ-003 SHALL have parameter VECTOR_DIMENSION, default 3, elements per vector.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-007 SHALL have port element_count  input  ADDR_WIDTH+1  total elements in job, sampled with start.
REQ-008 SHALL have port mem_addr  output  ADDR_WIDTH  element memory read address.
REQ-009 SHALL have port mem_rd_en  output  1  memory read strobe; data returns next cycle.
REQ-010 SHALL have port mem_data  input  ELEMENT_WIDTH  memory read data, valid one cycle after mem_rd_en.
REQ-011 SHALL have port element_out  output  ELEMENT_WIDTH  element to vector constructor.
REQ-012 SHALL have port element_valid  output  1  one-cycle qualifier for element_out.
REQ-013 SHALL have port vector_ready  input  1  constructor reports a complete vector.
REQ-014 SHALL have port mult_start  output  1  one-cycle pulse launching the multiplier.
REQ-015 SHALL have port mult_busy  input  1  multiplier busy.
REQ-016 SHALL have ports busy, done, error  output  1 each  job active / job-complete pulse / fault pulse.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WAIT_VEC, ISSUE, WAIT_MULT, DONE.
REQ-018 IDLE: on start=1 with element_count nonzero, a multiple of VECTOR_DIMENSION and <= 2^ADDR_WIDTH, SHALL latch count, clear address, enter FETCH next cycle.
REQ-019 IDLE: on start=1 with any other element_count SHALL pulse error one cycle, remain IDLE, issue no reads.
REQ-020 FETCH: SHALL assert mem_rd_en every cycle, mem_addr incrementing by 1 per cycle, for exactly VECTOR_DIMENSION cycles, then enter WAIT_VEC.
REQ-021 SHALL drive element_out=mem_data and element_valid=1 in the cycle after each mem_rd_en; element_out holds its last value otherwise.
REQ-022 mem_addr SHALL continue across vectors (vector k reads k*VECTOR_DIMENSION .. k*VECTOR_DIMENSION+VECTOR_DIMENSION-1) and never wrap within a legal job.
REQ-023 WAIT_VEC: SHALL wait for vector_ready=1, then enter ISSUE; vector_ready in other states SHALL be ignored.
REQ-024 WAIT_VEC: if vector_ready is not seen within 16 cycles of entry, SHALL pulse error, drop busy, return to IDLE.
REQ-025 ISSUE: SHALL pulse mult_start for one cycle in the first cycle mult_busy=0, then enter WAIT_MULT; while mult_busy=1 SHALL hold with mult_start=0.
REQ-026 WAIT_MULT: SHALL ignore mult_busy in its first cycle, then wait for mult_busy=0; if vectors remain enter FETCH, else DONE.
REQ-027 DONE: SHALL pulse done for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start while busy=1 SHALL be ignored with no effect.
REQ-030 Exactly element_count/VECTOR_DIMENSION mult_start pulses and element_count element_valid pulses SHALL occur per legal job.

Reset
REQ-031 reset=1 at any clock edge, including mid-job, SHALL force IDLE and clear counters and address.
REQ-032 Reset values: mem_addr=0, mem_rd_en=0, element_out=0, element_valid=0, mult_start=0, busy=0, done=0, error=0.
REQ-033 A read issued in the cycle before reset SHALL NOT produce element_valid after reset.

Verification
REQ-034 Reset: hold reset 5 cycles -> all outputs 0, state IDLE.
REQ-035 Normal: count=6, memory 0xAA00,0x1B480,0x5916,0x15F0,0x45557E,0x20000, vector_ready 2 cycles after third element, mult_busy high 3 cycles -> addresses 0..5, six element_valid pulses in order, two mult_start, one done, busy low afterwards.
REQ-036 Illegal count: start with count=4, then count=0, then count=9 -> one error pulse each, no mem_rd_en, busy stays 0.
REQ-037 Backpressure: mult_busy held high 5 cycles on ISSUE entry -> mult_start fires the first cycle mult_busy=0, exactly once.
REQ-038 Timeout: count=3, vector_ready held 0 -> error pulse 16 cycles after WAIT_VEC entry, no mult_start, returns IDLE.
REQ-039 Mid-job reset: reset at mem_addr=2 in FETCH -> next cycle all outputs 0; subsequent start count=3 reads from address 0.
